mem1port_arbiter: RTL and testbench
===================================

Name: mem1port_arbiter

Overview:
Two-master arbiter that sits directly upstream of the single-port RAM model in the SINGLE_RAM build. It merges the instruction-fetch port (read-only) and the data port (read/write) onto one ready/we/addr RAM interface. It routes each one-cycle-latency read response back to the master that issued it. Data has priority, with a starvation counter that guarantees instruction fetch forward progress.

Parameters:
STARVE_LIMIT, 4, consecutive cycles instruction may be refused before it takes priority; 0 means instruction has fixed priority.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
i_req  input  1  instruction read request; held with i_addr until i_gnt
i_addr  input  30  instruction word address [31:2]
i_gnt  output  1  instruction request accepted this cycle (combinational)
i_rvalid  output  1  instruction read data valid
i_rdata  output  32  instruction read data
d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_wstrb until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  30  data word address [31:2]
d_wdata  input  32  write data
d_wstrb  input  4  byte write strobes
d_gnt  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  data read data valid
d_rdata  output  32  data read data
m_ready  output  1  RAM access strobe
m_we  output  1  RAM write enable
m_addr  output  30  RAM word address
m_wdata  output  32  RAM write data
m_wstrb  output  4  RAM byte strobes
m_rresp  input  1  RAM read response; one cycle after a read strobe
m_rdata  input  32  RAM read data

Behaviour:
- Reset: starve_cnt=0, rsel=NONE. i_rvalid=d_rvalid=0 from the first cycle reset is high. Grants are forced 0 while reset=1.
- Priority select (combinational): i_pri = (starve_cnt >= STARVE_LIMIT).
  - d_gnt = d_req & !(i_pri & i_req).
  - i_gnt = i_req & !d_gnt.
  - At most one grant per cycle.
- RAM drive:
  - m_ready = i_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - m_addr = d_gnt ? d_addr : i_addr.
  - m_wdata = d_wdata; m_wstrb = d_gnt ? d_wstrb : 0.
- starve_cnt, updated per cycle:
  - If i_req & !i_gnt: increment, saturating at STARVE_LIMIT.
  - Otherwise: clear to 0.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- rsel register, updated every cycle:
  - I if i_gnt.
  - D if d_gnt & !d_we.
  - NONE otherwise (including data writes).
- Response routing:
  - i_rvalid = m_rresp & (rsel==I); d_rvalid = m_rresp & (rsel==D).
  - i_rdata = d_rdata = m_rdata, unregistered pass-through; validity is carried only by rvalid.
  - m_rresp while rsel==NONE is dropped: no rvalid.
- Throughput: one access per cycle, back-to-back grants allowed. Read latency is grant cycle + 1. Writes produce no response.
- Read-after-write ordering: a write granted in cycle N is visible to a read granted in cycle N+1, because the RAM is single-port and writes complete at the edge.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no rvalid. The master must reissue it.

Test Plan:
- I-only read of i_addr=0x4 (RAM word 0x4 = 0xDEADBEEF), d_req=0 -> i_gnt=1 in cycle 0; i_rvalid=1 and i_rdata=0xDEADBEEF in cycle 1; d_rvalid stays 0.
- i_req and d_req both held high (reads), STARVE_LIMIT=4 -> d_gnt in cycles 0-3, i_gnt in cycle 4, d_gnt in cycles 5-8, i_gnt in cycle 9; starve_cnt returns to 0 after each i_gnt.
- D write of 0x1234_5678 to word 0x8 with d_wstrb=4'b0011 (old value 0xAAAA_AAAA), then I read of 0x8 next cycle -> no d_rvalid for the write; i_rdata=0xAAAA_5678.
- D read of 0x10, then I read of 0x14 in the following cycle -> d_rvalid only in cycle 1, i_rvalid only in cycle 2, each with the correct word.
- Grant a D read in cycle 0 and assert reset in cycle 1 -> d_rvalid=0 in cycle 1; all grants 0 while reset=1; starve_cnt=0 afterwards.
- STARVE_LIMIT=0, both requesting continuously -> i_gnt every cycle, d_gnt never.

Source files
------------

// File: rtl/mem1port_arbiter_if.sv
// Bus bundle between the instruction/data masters, the arbiter and the single-port RAM.
// slave = arbiter view; master = the surrounding masters and RAM model.
interface mem1port_arbiter_if;
   // Instruction fetch port (read-only)
   logic        i_req;
   logic [29:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   // Data port
   logic        d_req;
   logic        d_we;
   logic [29:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   // RAM side
   logic        m_ready;
   logic        m_we;
   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_rresp;
   logic [31:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rresp, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_ready, m_we, m_addr, m_wdata, m_wstrb
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rresp, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_ready, m_we, m_addr, m_wdata, m_wstrb
   );
endinterface

// File: rtl/mem1port_arbiter.sv
// Merges instruction-fetch and data masters onto one single-port RAM, data first,
// with a starvation counter that eventually forces an instruction grant.
module mem1port_arbiter #(
   parameter int  STARVE_LIMIT = 4,
   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   mem1port_arbiter_if.slave bus,
   output logic [CW-1:0]     dbg_starve_cnt,
   output logic [1:0]        dbg_rsel
);

   // Handshake: a master holds req and its payload stable until the cycle gnt
   // is high; gnt is combinational and the transfer happens on that clock edge.
   // A read returns exactly one cycle later as rvalid; writes return nothing.

   typedef enum logic [1:0] {
      RSEL_NONE = 2'd0,
      RSEL_I    = 2'd1,
      RSEL_D    = 2'd2
   } rsel_t;

   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   rsel_t         rsel, rsel_next;
   logic [CW-1:0] starve_cnt, starve_next;
   logic          i_pri, i_gnt, d_gnt;

   // The counter saturates at LIM, so equality is the same as >= LIM.
   assign i_pri = (starve_cnt == LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         rsel       <= RSEL_NONE;
         starve_cnt <= '0;
      end else begin
         rsel       <= rsel_next;
         starve_cnt <= starve_next;
      end
   end

   always_comb begin
      d_gnt       = 1'b0;
      i_gnt       = 1'b0;
      rsel_next   = RSEL_NONE;
      starve_next = '0;
      if (!reset) begin
         d_gnt = bus.d_req & !(i_pri & bus.i_req);
         i_gnt = bus.i_req & !d_gnt;
         if (i_gnt)
            rsel_next = RSEL_I;
         else if (d_gnt & !bus.d_we)
            rsel_next = RSEL_D;
         if (bus.i_req & !i_gnt)
            starve_next = (starve_cnt == LIM) ? starve_cnt : starve_cnt + 1'b1;
      end
   end

   assign bus.i_gnt   = i_gnt;
   assign bus.d_gnt   = d_gnt;
   assign bus.m_ready = i_gnt | d_gnt;
   assign bus.m_we    = d_gnt & bus.d_we;
   assign bus.m_addr  = d_gnt ? bus.d_addr : bus.i_addr;
   assign bus.m_wdata = bus.d_wdata;
   assign bus.m_wstrb = d_gnt ? bus.d_wstrb : 4'b0000;

   // A response already in flight when reset rises is discarded.
   assign bus.i_rvalid = bus.m_rresp & (rsel == RSEL_I) & !reset;
   assign bus.d_rvalid = bus.m_rresp & (rsel == RSEL_D) & !reset;
   assign bus.i_rdata  = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;

   assign dbg_starve_cnt = starve_cnt;
   assign dbg_rsel       = rsel;

endmodule

// File: tb/tb_mem1port_arbiter.sv
// Directed bench for mem1port_arbiter: default starvation limit plus a fixed-priority
// (STARVE_LIMIT=0) instance, with a one-cycle-latency RAM model behind the first.
module tb_mem1port_arbiter;

   logic       clk;
   logic       reset;
   logic [2:0] starve0;
   logic [1:0] rsel0;
   logic [0:0] starve1;
   logic [1:0] rsel1;
   int         checks;
   int         errors;
   logic [31:0] mem [0:63];

   mem1port_arbiter_if bus0 ();
   mem1port_arbiter_if bus1 ();

   mem1port_arbiter #(.STARVE_LIMIT(4)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave),
      .dbg_starve_cnt(starve0), .dbg_rsel(rsel0)
   );

   mem1port_arbiter #(.STARVE_LIMIT(0)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave),
      .dbg_starve_cnt(starve1), .dbg_rsel(rsel1)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM model: writes complete at the edge, reads answer next cycle
   always @(posedge clk) begin
      bus0.m_rresp <= 1'b0;
      if (bus0.m_ready) begin
         if (bus0.m_we) begin
            for (int b = 0; b < 4; b++)
               if (bus0.m_wstrb[b]) mem[bus0.m_addr[5:0]][8*b +: 8] <= bus0.m_wdata[8*b +: 8];
         end else begin
            bus0.m_rresp <= 1'b1;
            bus0.m_rdata <= mem[bus0.m_addr[5:0]];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      bus0.i_req   = 1'b0;
      bus0.i_addr  = '0;
      bus0.d_req   = 1'b0;
      bus0.d_we    = 1'b0;
      bus0.d_addr  = '0;
      bus0.d_wdata = '0;
      bus0.d_wstrb = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus0.i_req = 1'b1;
      bus0.d_req = 1'b1;
      bus1.i_req = 1'b1;
      bus1.d_req = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++; if (bus0.i_gnt !== 1'b0 || bus0.d_gnt !== 1'b0) begin
         errors++; $display("FAIL reset_gnt0 got i=%b d=%b want 0 0", bus0.i_gnt, bus0.d_gnt);
      end
      checks++; if (bus1.i_gnt !== 1'b0 || bus1.d_gnt !== 1'b0) begin
         errors++; $display("FAIL reset_gnt1 got i=%b d=%b want 0 0", bus1.i_gnt, bus1.d_gnt);
      end
      checks++; if (bus0.m_ready !== 1'b0) begin
         errors++; $display("FAIL reset_m_ready got %b want 0", bus0.m_ready);
      end
      checks++; if (bus0.i_rvalid !== 1'b0 || bus0.d_rvalid !== 1'b0) begin
         errors++; $display("FAIL reset_rvalid got i=%b d=%b want 0 0", bus0.i_rvalid, bus0.d_rvalid);
      end
      checks++; if (starve0 !== 3'd0 || rsel0 !== 2'd0) begin
         errors++; $display("FAIL reset_state got starve=%0d rsel=%0d want 0 0", starve0, rsel0);
      end
      tick();
      reset = 1'b0;
      idle0();
      bus1.i_req = 1'b0;
      bus1.d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_i_read();
      tick();
      bus0.i_req  = 1'b1;
      bus0.i_addr = 30'h4;
      @(negedge clk);
      checks++; if (bus0.i_gnt !== 1'b1 || bus0.d_gnt !== 1'b0) begin
         errors++; $display("FAIL i_read_gnt got i=%b d=%b want 1 0", bus0.i_gnt, bus0.d_gnt);
      end
      checks++; if (bus0.m_addr !== 30'h4 || bus0.m_we !== 1'b0 || bus0.m_wstrb !== 4'b0) begin
         errors++; $display("FAIL i_read_bus got addr=%h we=%b strb=%b want 4 0 0", bus0.m_addr, bus0.m_we, bus0.m_wstrb);
      end
      tick();
      idle0();
      @(negedge clk);
      checks++; if (bus0.i_rvalid !== 1'b1 || bus0.i_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL i_read_resp got v=%b data=%h want 1 deadbeef", bus0.i_rvalid, bus0.i_rdata);
      end
      checks++; if (bus0.d_rvalid !== 1'b0) begin
         errors++; $display("FAIL i_read_d_rvalid got %b want 0", bus0.d_rvalid);
      end
   endtask

   task automatic test_starvation();
      logic exp_i, prev_i, prev_d;
      prev_i = 1'b0;
      prev_d = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c == 0) begin
            bus0.i_req  = 1'b1;
            bus0.i_addr = 30'h14;
            bus0.d_req  = 1'b1;
            bus0.d_we   = 1'b0;
            bus0.d_addr = 30'h10;
         end
         @(negedge clk);
         exp_i = (c == 4) || (c == 9);
         checks++; if (bus0.i_gnt !== exp_i || bus0.d_gnt !== !exp_i) begin
            errors++; $display("FAIL starve_gnt c=%0d got i=%b d=%b want %b %b", c, bus0.i_gnt, bus0.d_gnt, exp_i, !exp_i);
         end
         checks++; if (starve0 !== 3'(c % 5)) begin
            errors++; $display("FAIL starve_cnt c=%0d got %0d want %0d", c, starve0, c % 5);
         end
         if (c > 0) begin
            checks++; if (bus0.i_rvalid !== prev_i || bus0.d_rvalid !== prev_d) begin
               errors++; $display("FAIL starve_route c=%0d got i=%b d=%b want %b %b", c, bus0.i_rvalid, bus0.d_rvalid, prev_i, prev_d);
            end
         end
         prev_i = exp_i;
         prev_d = !exp_i;
      end
      tick();
      idle0();
      @(negedge clk);
      checks++; if (bus0.i_rvalid !== 1'b1 || bus0.i_rdata !== 32'h2222_0014 || bus0.d_rvalid !== 1'b0) begin
         errors++; $display("FAIL starve_last got iv=%b data=%h dv=%b want 1 22220014 0", bus0.i_rvalid, bus0.i_rdata, bus0.d_rvalid);
      end
      checks++; if (starve0 !== 3'd0) begin
         errors++; $display("FAIL starve_clear got %0d want 0", starve0);
      end
   endtask

   task automatic test_write_then_read();
      tick();
      bus0.d_req   = 1'b1;
      bus0.d_we    = 1'b1;
      bus0.d_addr  = 30'h8;
      bus0.d_wdata = 32'h1234_5678;
      bus0.d_wstrb = 4'b0011;
      @(negedge clk);
      checks++; if (bus0.d_gnt !== 1'b1 || bus0.m_we !== 1'b1 || bus0.m_wstrb !== 4'b0011 || bus0.m_wdata !== 32'h1234_5678) begin
         errors++; $display("FAIL wr_bus got gnt=%b we=%b strb=%b data=%h want 1 1 0011 12345678", bus0.d_gnt, bus0.m_we, bus0.m_wstrb, bus0.m_wdata);
      end
      tick();
      idle0();
      bus0.i_req  = 1'b1;
      bus0.i_addr = 30'h8;
      @(negedge clk);
      checks++; if (bus0.i_gnt !== 1'b1 || bus0.d_rvalid !== 1'b0 || bus0.i_rvalid !== 1'b0) begin
         errors++; $display("FAIL wr_noresp got ig<nt=%b dv=%b iv=%b want 1 0 0", bus0.i_gnt, bus0.d_rvalid, bus0.i_rvalid);
      end
      tick();
      idle0();
      @(negedge clk);
      checks++; if (bus0.i_rvalid !== 1'b1 || bus0.i_rdata !== 32'hAAAA_5678 || bus0.d_rvalid !== 1'b0) begin
         errors++; $display("FAIL raw_read got iv=%b data=%h dv=%b want 1 aaaa5678 0", bus0.i_rvalid, bus0.i_rdata, bus0.d_rvalid);
      end
   endtask

   task automatic test_back_to_back();
      tick();
      bus0.d_req  = 1'b1;
      bus0.d_we   = 1'b0;
      bus0.d_addr = 30'h10;
      @(negedge clk);
      checks++; if (bus0.d_gnt !== 1'b1 || bus0.m_addr !== 30'h10) begin
         errors++; $display("FAIL b2b_d_gnt got gnt=%b addr=%h want 1 10", bus0.d_gnt, bus0.m_addr);
      end
      tick();
      idle0();
      bus0.i_req  = 1'b1;
      bus0.i_addr = 30'h14;
      @(negedge clk);
      checks++; if (bus0.d_rvalid !== 1'b1 || bus0.d_rdata !== 32'h1111_0010 || bus0.i_rvalid !== 1'b0) begin
         errors++; $display("FAIL b2b_d_resp got dv=%b data=%h iv=%b want 1 11110010 0", bus0.d_rvalid, bus0.d_rdata, bus0.i_rvalid);
      end
      tick();
      idle0();
      @(negedge clk);
      checks++; if (bus0.i_rvalid !== 1'b1 || bus0.i_rdata !== 32'h2222_0014 || bus0.d_rvalid !== 1'b0) begin
         errors++; $display("FAIL b2b_i_resp got iv=%b data=%h dv=%b want 1 22220014 0", bus0.i_rvalid, bus0.i_rdata, bus0.d_rvalid);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      bus0.d_req  = 1'b1;
      bus0.d_we   = 1'b0;
      bus0.d_addr = 30'h10;
      bus0.i_req  = 1'b1;
      bus0.i_addr = 30'h14;
      @(negedge clk);
      checks++; if (bus0.d_gnt !== 1'b1) begin
         errors++; $display("FAIL rst_mid_gnt got %b want 1", bus0.d_gnt);
      end
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus0.d_rvalid !== 1'b0 || bus0.i_rvalid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_rvalid got d=%b i=%b want 0 0", bus0.d_rvalid, bus0.i_rvalid);
      end
      checks++; if (bus0.d_gnt !== 1'b0 || bus0.i_gnt !== 1'b0 || bus0.m_ready !== 1'b0) begin
         errors++; $display("FAIL rst_mid_gnt_off got d=%b i=%b rdy=%b want 0 0 0", bus0.d_gnt, bus0.i_gnt, bus0.m_ready);
      end
      tick();
      reset = 1'b0;
      idle0();
      @(negedge clk);
      checks++; if (starve0 !== 3'd0 || rsel0 !== 2'd0 || bus0.d_rvalid !== 1'b0 || bus0.i_rvalid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_after got starve=%0d rsel=%0d dv=%b iv=%b want 0 0 0 0", starve0, rsel0, bus0.d_rvalid, bus0.i_rvalid);
      end
   endtask

   task automatic test_fixed_priority();
      tick();
      bus1.i_req  = 1'b1;
      bus1.i_addr = 30'h20;
      bus1.d_req  = 1'b1;
      bus1.d_we   = 1'b0;
      bus1.d_addr = 30'h30;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         checks++; if (bus1.i_gnt !== 1'b1 || bus1.d_gnt !== 1'b0 || bus1.m_addr !== 30'h20) begin
            errors++; $display("FAIL fixed_pri c=%0d got i=%b d=%b addr=%h want 1 0 20", c, bus1.i_gnt, bus1.d_gnt, bus1.m_addr);
         end
      end
      checks++; if (starve1 !== 1'b0) begin
         errors++; $display("FAIL fixed_pri_cnt got %0d want 0", starve1);
      end
      tick();
      bus1.i_req = 1'b0;
      bus1.d_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int k = 0; k < 64; k++) mem[k] = 32'h0;
      mem[4]  = 32'hDEAD_BEEF;
      mem[8]  = 32'hAAAA_AAAA;
      mem[16] = 32'h1111_0010;
      mem[20] = 32'h2222_0014;
      reset = 1'b1;
      idle0();
      bus0.m_rresp = 1'b0;
      bus0.m_rdata = '0;
      bus1.i_req   = 1'b0;
      bus1.i_addr  = '0;
      bus1.d_req   = 1'b0;
      bus1.d_we    = 1'b0;
      bus1.d_addr  = '0;
      bus1.d_wdata = '0;
      bus1.d_wstrb = '0;
      bus1.m_rresp = 1'b0;
      bus1.m_rdata = '0;

      test_reset();
      test_i_read();
      test_starvation();
      test_write_then_read();
      test_back_to_back();
      test_reset_mid();
      test_fixed_priority();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
